ff_stim_seq: RTL

FF_STIM_SEQ -- requirements
Module: ff_stim_seq

---
 rtl/ff_stim_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ff_stim_seq.sv
// rtl/ff_stim_seq.sv - clear/data stimulus sequencer for a downstream flip-flop
// Optional response checker compiled in with `define FF_STIM_CHECK_EN.
module ff_stim_seq #(
  parameter int ITER     = 5,
  parameter int CLR_CYC  = 2,
  parameter int HOLD_CYC = 4
) (
  input  logic        ck,
  input  logic        clr,
  input  logic        start,
  input  logic        q,
  input  logic        qb,
  output logic        dut_clr,
  output logic        dut_d,
  output logic        busy,
  output logic        done,
  output logic [7:0]  iter,
  output logic [15:0] err_cnt,
  output logic        err
);

  localparam logic [7:0] CLR_LEN   = 8'(CLR_CYC);
  localparam logic [7:0] HOLD_LEN  = 8'(HOLD_CYC);
  localparam logic [7:0] ITER_LAST = 8'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_D_LOW, S_D_HIGH, S_D_LOW2, S_GAP, S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] phase_len;
  logic       phase_last;
  logic       go;
  logic       dut_clr_nxt, dut_d_nxt, busy_nxt, done_nxt;

  assign phase_len  = (state == S_CLR) ? CLR_LEN : HOLD_LEN;
  assign phase_last = (cnt == phase_len - 8'd1);
  assign go         = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge ck) begin
    if (clr) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= ((state_nxt != state) || !busy_nxt) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_CLR;
      S_CLR:          if (phase_last) state_nxt = S_D_LOW;
      S_D_LOW:        if (phase_last) state_nxt = S_D_HIGH;
      S_D_HIGH:       if (phase_last) state_nxt = S_D_LOW2;
      S_D_LOW2:       if (phase_last) state_nxt = S_GAP;
      S_GAP:          if (phase_last) state_nxt = (iter < ITER_LAST) ? S_CLR : S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    dut_clr_nxt = (state_nxt == S_IDLE) || (state_nxt == S_CLR);
    dut_d_nxt   = !((state_nxt == S_D_LOW) || (state_nxt == S_D_LOW2));
    busy_nxt    = !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
    done_nxt    = (state_nxt == S_DONE);
  end

  always_ff @(posedge ck) begin
    if (clr) begin
      dut_clr <= 1'b1;
      dut_d   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      iter    <= 8'd0;
    end else begin
      dut_clr <= dut_clr_nxt;
      dut_d   <= dut_d_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      if (go)
        iter <= 8'd0;
      else if ((state == S_GAP) && phase_last && (iter < ITER_LAST))
        iter <= iter + 8'd1;
    end
  end

`ifdef FF_STIM_CHECK_EN
  // Each busy cycle's drive is captured at its closing edge and the flop's
  // response is compared one cycle later, when it has had a clock to settle.
  logic first_r, chk_vld_r, exp_q_r, bad;

  assign bad = chk_vld_r && ((q != exp_q_r) || (q == qb));

  always_ff @(posedge ck) begin
    if (clr) begin
      first_r   <= 1'b0;
      chk_vld_r <= 1'b0;
      exp_q_r   <= 1'b0;
      err_cnt   <= 16'd0;
      err       <= 1'b0;
    end else begin
      first_r   <= go;
      chk_vld_r <= busy && !first_r;
      exp_q_r   <= dut_clr ? 1'b0 : dut_d;
      if (go) begin
        err_cnt <= 16'd0;
        err     <= 1'b0;
      end else if (bad) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        err <= 1'b1;
      end
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{q, qb};
  assign err_cnt     = 16'd0;
  assign err         = 1'b0;
`endif

endmodule
